// File: rtl/dht11_responder.sv
// dht11_responder: DHT11 sensor emulator that answers a host start pulse with presence and a 40-bit frame
module dht11_responder #(
  parameter int unsigned CLK_FREQ      = 50_000_000,
  parameter int unsigned START_MIN_US  = 18000,
  parameter int unsigned TURNAROUND_US = 30,
  parameter int unsigned RESP_LOW_US   = 80,
  parameter int unsigned RESP_HIGH_US  = 80,
  parameter int unsigned BIT_LOW_US    = 50,
  parameter int unsigned BIT0_HIGH_US  = 26,
  parameter int unsigned BIT1_HIGH_US  = 70
) (
  input  logic       clk,
  input  logic       rst,
  inout  wire        dht11,
  input  logic       enable,
  input  logic [7:0] hum_int,
  input  logic [7:0] hum_dec,
  input  logic [7:0] temp_int,
  input  logic [7:0] temp_dec,
  input  logic       bad_csum,
  output logic       busy,
  output logic       frame_done,
  output logic [7:0] frame_count
);
  localparam int unsigned US_CYC = CLK_FREQ / 1_000_000;
  localparam logic [31:0] START_C = 32'(START_MIN_US * US_CYC);
  localparam logic [31:0] TURN_C  = 32'(TURNAROUND_US * US_CYC);
  localparam logic [31:0] RL_C    = 32'(RESP_LOW_US * US_CYC);
  localparam logic [31:0] RH_C    = 32'(RESP_HIGH_US * US_CYC);
  localparam logic [31:0] BL_C    = 32'(BIT_LOW_US * US_CYC);
  localparam logic [31:0] B0_C    = 32'(BIT0_HIGH_US * US_CYC);
  localparam logic [31:0] B1_C    = 32'(BIT1_HIGH_US * US_CYC);
  typedef enum logic [3:0] {
    IDLE, START_LOW, TURNAROUND, RESP_LOW, RESP_HIGH, BIT_LOW, BIT_HIGH, END_LOW, RECOVER
  } state_t;
  state_t state, state_n;
  logic s1, line_s, line_d, drive_low, seg_end, fell, fin;
  logic [31:0] timer, seg_len;
  logic [39:0] sh;
  logic [5:0] bit_idx;
  logic [7:0] csum;
  assign dht11 = drive_low ? 1'b0 : 1'bz;
  assign busy = state inside {TURNAROUND, RESP_LOW, RESP_HIGH, BIT_LOW, BIT_HIGH, END_LOW};
  assign fell = line_d & ~line_s;
  assign fin = drive_low && state == RECOVER;
  assign csum = hum_int + hum_dec + temp_int + temp_dec;
  always_comb begin
    seg_len = state == TURNAROUND ? TURN_C :
              state == RESP_LOW   ? RL_C :
              state == RESP_HIGH  ? RH_C :
              state == BIT_HIGH   ? (sh[39] ? B1_C : B0_C) : BL_C;
    seg_end = timer == seg_len - 32'd1;
    state_n = state;
    case (state)
      IDLE:       state_n = fell && enable ? START_LOW : IDLE;
      START_LOW:  state_n = !line_s ? START_LOW : timer >= START_C - 32'd1 ? TURNAROUND : IDLE;
      TURNAROUND: state_n = seg_end ? RESP_LOW : state;
      RESP_LOW:   state_n = seg_end ? RESP_HIGH : state;
      RESP_HIGH:  state_n = seg_end ? BIT_LOW : state;
      BIT_LOW:    state_n = seg_end ? BIT_HIGH : state;
      BIT_HIGH:   state_n = !seg_end ? state : bit_idx == 6'd39 ? END_LOW : BIT_LOW;
      END_LOW:    state_n = seg_end ? RECOVER : state;
      RECOVER:    state_n = line_s ? IDLE : state;
      default:    state_n = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (!rst) begin
      {line_d, line_s, s1} <= 3'b111;
      state <= IDLE;
      timer <= '0;
      sh <= '0;
      bit_idx <= '0;
      drive_low <= 1'b0;
      frame_done <= 1'b0;
      frame_count <= '0;
    end else begin
      {line_d, line_s, s1} <= {line_s, s1, dht11};
      state <= state_n;
      timer <= state_n != state ? '0 : (state == START_LOW && timer == START_C) ? timer : timer + 32'd1;
      if (state_n == TURNAROUND && state != TURNAROUND) begin
        sh <= {hum_int, hum_dec, temp_int, temp_dec, csum ^ {8{bad_csum}}};
        bit_idx <= '0;
      end else if (state == BIT_HIGH && seg_end) begin
        sh <= {sh[38:0], 1'b0};
        bit_idx <= bit_idx + 6'd1;
      end
      drive_low <= state inside {RESP_LOW, BIT_LOW, END_LOW};
      frame_done <= fin;
      frame_count <= frame_count + 8'(fin);
    end
  end
endmodule

// File: tb/tb_dht11_responder.sv
// tb_dht11_responder: randomized host stimulus checked cycle by cycle against a waveform model of the DHT11 frame
module tb_dht11_responder;
  localparam int TURN = 30, RL = 80, RH = 80, BL = 50, B0 = 26, B1 = 70;
  typedef struct packed {logic drv; logic busy; logic done;} exp_t;
  logic clk = 1'b0, rst = 1'b0, enable = 1'b1, bad_csum = 1'b0, host_low = 1'b0, run = 1'b0;
  logic [7:0] hum_int = '0, hum_dec = '0, temp_int = '0, temp_dec = '0;
  logic busy, frame_done;
  logic [7:0] frame_count;
  wire dht11;
  exp_t q[$];
  int errors = 0, checks = 0, rx_n = 0, hi_run = 0;
  logic [7:0] exp_count = '0;
  logic [39:0] rx = '0, want;
  logic prev_line = 1'b1;
  pullup (dht11);
  assign dht11 = host_low ? 1'b0 : 1'bz;
  dht11_responder #(.CLK_FREQ(1_000_000), .START_MIN_US(100)) dut (
    .clk(clk), .rst(rst), .dht11(dht11), .enable(enable),
    .hum_int(hum_int), .hum_dec(hum_dec), .temp_int(temp_int), .temp_dec(temp_dec),
    .bad_csum(bad_csum), .busy(busy), .frame_done(frame_done), .frame_count(frame_count)
  );
  always #5 clk = ~clk;
  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask
  function automatic logic [39:0] payload();
    logic [7:0] s;
    s = hum_int + hum_dec + temp_int + temp_dec;
    return {hum_int, hum_dec, temp_int, temp_dec, bad_csum ? ~s : s};
  endfunction
  task automatic seg(input logic lvl, input int n);
    for (int i = 0; i < n; i++) q.push_back('{lvl, 1'b1, 1'b0});
  endtask
  task automatic push_frame(input logic [39:0] bits);
    for (int i = 0; i < 3; i++) q.push_back('{1'b0, 1'b0, 1'b0});
    seg(1'b0, TURN + 1);
    seg(1'b1, RL);
    seg(1'b0, RH);
    for (int i = 39; i >= 0; i--) begin
      seg(1'b1, BL);
      seg(1'b0, bits[i] ? B1 : B0);
    end
    seg(1'b1, BL - 1);
    q.push_back('{1'b1, 1'b0, 1'b0});
    q.push_back('{1'b0, 1'b0, 1'b1});
  endtask
  task automatic frame(input int n, input bit expect_frame);
    @(posedge clk);
    #1 host_low = 1'b1;
    repeat (n) @(posedge clk);
    #1 host_low = 1'b0;
    if (expect_frame) push_frame(payload());
  endtask
  task automatic wait_frame();
    int n = 0;
    while (q.size() != 0 && n < 8000) begin
      @(posedge clk);
      n++;
    end
    check("frame_end", 64'(q.size()), 0);
    repeat (20) @(posedge clk);
  endtask
  task automatic wait_bits(input int k);
    int n = 0;
    while (rx_n != k && n < 6000) begin
      @(posedge clk);
      n++;
    end
    check("reach_bit", 64'(rx_n), 64'(k));
  endtask
  task automatic set_payload(input logic [31:0] p);
    {hum_int, hum_dec, temp_int, temp_dec} = p;
  endtask
  initial begin
    forever begin
      exp_t e;
      @(negedge clk);
      if (run) begin
        e = '0;
        if (q.size() != 0) e = q.pop_front();
        exp_count = exp_count + 8'(e.done);
        if (!host_low) check("drive", 64'(dht11 == 1'b0), 64'(e.drv));
        check("status", {busy, frame_done, frame_count}, {e.busy, e.done, exp_count});
      end
    end
  end
  initial begin
    forever begin
      @(negedge clk);
      if (dht11) hi_run = hi_run + 1;
      else begin
        if (prev_line) begin
          if (hi_run > 75) rx_n = 0;
          else if (rx_n < 40) begin
            rx = {rx[38:0], 1'(hi_run > 48)};
            rx_n = rx_n + 1;
          end
        end
        hi_run = 0;
      end
      prev_line = dht11;
    end
  end
  initial begin
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;
    run = 1'b1;
    @(negedge clk);
    check("rst_line", 64'(dht11), 1);
    check("rst_busy", 64'(busy), 0);
    check("rst_done", 64'(frame_done), 0);
    check("rst_count", 64'(frame_count), 0);
    set_payload(32'h37001803);
    frame(150, 1'b1);
    wait_bits(20);
    @(posedge clk);
    #1 rst = 1'b0;
    @(posedge clk);
    #1 q.delete();
    rst = 1'b1;
    @(negedge clk);
    check("abort_line", 64'(dht11), 1);
    check("abort_busy", 64'(busy), 0);
    check("abort_count", 64'(frame_count), 0);
    repeat (200) @(posedge clk);
    frame(150, 1'b1);
    wait_frame();
    check("basic_rx", rx, 40'h3700180352);
    check("basic_count", 64'(frame_count), 1);
    set_payload(32'hFFFF0102);
    frame(120, 1'b1);
    wait_frame();
    check("wrap_csum", 64'(rx[7:0]), 8'h01);
    bad_csum = 1'b1;
    frame(120, 1'b1);
    wait_frame();
    check("bad_csum", 64'(rx[7:0]), 8'hFE);
    bad_csum = 1'b0;
    frame(99, 1'b0);
    repeat (300) @(posedge clk);
    check("short_count", 64'(frame_count), 3);
    frame(100, 1'b1);
    wait_frame();
    check("min_start_rx", rx, 40'hFFFF010201);
    check("min_start_count", 64'(frame_count), 4);
    set_payload(32'h37001803);
    frame(150, 1'b1);
    wait_bits(10);
    #1 temp_int = 8'h20;
    enable = 1'b0;
    bad_csum = 1'b1;
    wait_frame();
    check("snap_rx", rx, 40'h3700180352);
    enable = 1'b1;
    bad_csum = 1'b0;
    frame(150, 1'b1);
    wait_frame();
    check("snap_next_rx", rx, 40'h370020035A);
    enable = 1'b0;
    frame(150, 1'b0);
    repeat (300) @(posedge clk);
    check("disabled_count", 64'(frame_count), 6);
    enable = 1'b1;
    set_payload(32'hAA550000);
    frame(150, 1'b1);
    wait_frame();
    check("alt_rx", rx, 40'hAA550000FF);
    for (int k = 0; k < 3; k++) begin
      frame($urandom_range(5, 99), 1'b0);
      repeat (50) @(posedge clk);
      set_payload($urandom);
      bad_csum = 1'($urandom_range(0, 1));
      want = payload();
      frame($urandom_range(100, 400), 1'b1);
      wait_frame();
      check("rand_rx", rx, want);
    end
    check("final_count", 64'(frame_count), 10);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/dht11_responder.md
# dht11_responder

Synthesizable DHT11 single-wire sensor emulator: the responder side of the temperature-sensor link that `Sensores` drives as initiator. It sits on the `sns_temp` pin in place of a physical DHT11 and serves lab bring-up and test mode. It detects the host start pulse, answers with the DHT11 presence sequence, then transmits a 40-bit frame built from programmable humidity and temperature bytes plus checksum.

## Interface
- `CLK_FREQ`, default 50_000_000: clock frequency in Hz. `US_CYC = CLK_FREQ/1_000_000` cycles per microsecond.
- `START_MIN_US`, default 18000: minimum host low time accepted as a start pulse.
- `TURNAROUND_US`, default 30: delay from host release to the first responder low.
- `RESP_LOW_US`, default 80; `RESP_HIGH_US`, default 80: presence low and presence high.
- `BIT_LOW_US`, default 50: low preamble of every bit, also used as the end-of-frame low.
- `BIT0_HIGH_US`, default 26; `BIT1_HIGH_US`, default 70: high time for a 0 bit and a 1 bit.

Ports:
- `clk` in 1: system clock.
- `rst` in 1: synchronous reset, active-low.
- `dht11` inout 1: open-drain line; the block drives only `0` or `z`, and the pull-up is external.
- `enable` in 1: when low, start pulses are ignored.
- `hum_int`, `hum_dec`, `temp_int`, `temp_dec` in 8 each: payload bytes.
- `bad_csum` in 1: when high, the transmitted checksum is inverted (fault injection).
- `busy` out 1: high while the block owns the line.
- `frame_done` out 1: one-cycle pulse at the end of each frame.
- `frame_count` out 8: frames sent; wraps from 255 to 0.

## Operation
- The `dht11` input passes through a 2-flop synchronizer to give `line_s`. All detection uses `line_s`.
- The pin drive is a registered `drive_low`; `dht11 = drive_low ? 0 : z`.
- A single timer counts cycles and is reloaded on every state entry. A segment of N µs lasts exactly N·US_CYC cycles.
- State machine:
  - **IDLE**: on `line_s` falling edge with `enable`=1, go to START_LOW and clear the timer.
  - **START_LOW**: the timer counts while `line_s`=0 and saturates at the START_MIN_US cycle count. When `line_s` rises:
    - if the low time was at least START_MIN_US·US_CYC, go to TURNAROUND;
    - otherwise go back to IDLE (glitch or short pulse).
  - **TURNAROUND** (TURNAROUND_US): on entry, snapshot the 4 payload bytes and `bad_csum`. Checksum = (h_i+h_d+t_i+t_d) mod 256, inverted if the snapshotted `bad_csum`=1.
  - **RESP_LOW** (`drive_low`=1, RESP_LOW_US), then **RESP_HIGH** (released, RESP_HIGH_US).
  - **BIT_LOW** (BIT_LOW_US), then **BIT_HIGH** (BIT1_HIGH_US or BIT0_HIGH_US). Repeat for bit index 0..39.
  - **END_LOW** (BIT_LOW_US): release the line, pulse `frame_done`, increment `frame_count`, go to RECOVER.
  - **RECOVER**: wait until `line_s`=1, then go to IDLE. This prevents self-triggering on the synchronizer lag after release.
- Frame order: `hum_int`, `hum_dec`, `temp_int`, `temp_dec`, checksum, each sent MSB first.
- Payload input changes after the snapshot do not affect the frame in progress.
- `enable` is sampled only in IDLE. Deasserting it mid-frame has no effect.
- From TURNAROUND through END_LOW the block does not sample the line; a host driving low meanwhile is ignored.
- `busy`=1 in TURNAROUND..END_LOW, and 0 elsewhere.

## Timing
- Reset values: `drive_low`=0 (line released), `busy`=0, `frame_done`=0, `frame_count`=0, state IDLE, synchronizer flops=1.
- Reset asserted mid-frame: on the next clock edge the line is released and the state is IDLE. No `frame_done` pulse and no count increment.
- Host-release latency: from the pin rising edge to `dht11` driven low is 2 synchronizer cycles + 1 edge-detect cycle + TURNAROUND_US·US_CYC cycles + 1 register cycle.
- Each driven segment is exact to ±0 cycles relative to its state entry. There is no gap between consecutive segments.
- Frame length from the first responder low to the final release: RESP_LOW + RESP_HIGH + 40·BIT_LOW + Σ(bit highs) + BIT_LOW, all in µs·US_CYC.
- `frame_done` is asserted in the same cycle that `drive_low` falls to 0 after END_LOW.
- A host low that stays low indefinitely holds START_LOW with the timer saturated; no response is produced until the rising edge.

## Test plan
- Sim parameters: CLK_FREQ=1_000_000, START_MIN_US=100.
- Basic frame: payload 0x37,0x00,0x18,0x03; host low 150 µs then release → presence 80 µs low / 80 µs high, bytes decoded as 37 00 18 03 52, `frame_done` pulses once, `frame_count`=1.
- Checksum wrap: payload 0xFF,0xFF,0x01,0x02 → checksum 0x01. With `bad_csum`=1, checksum 0xFE.
- Short start: host low 99 µs → no drive, `busy` stays 0. A following low of exactly 100 µs → full frame.
- Snapshot: change `temp_int` from 0x18 to 0x20 at bit 10 → the frame still carries 0x18; the next frame carries 0x20.
- `enable`=0 during start → no response. Reset asserted at bit 20 → line released next cycle, `frame_count` unchanged, and a new start afterwards gives a valid frame.
- Bit timing: payload 0xAA,0x55,0x00,0x00 → alternating bit high times of 70/26 µs, with every preamble exactly 50 µs.
